// File: rtl/harvest_vote_filter.sv
// Majority-vote filter with hysteresis over the last WIN classifier results.
// Produces a debounced harvest decision, a rise pulse and a saturating rise counter.
module harvest_vote_filter #(
  parameter int WIN    = 8,
  parameter int ON_TH  = 6,
  parameter int OFF_TH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cls_valid,
  input  logic       cls_in,
  input  logic       clr,
  output logic       harvest,
  output logic       harvest_rise,
  output logic       stable,
  output logic [3:0] vote_cnt,
  output logic [7:0] event_cnt
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    NOT_READY = 2'd1,
    READY     = 2'd2
  } state_t;

  localparam logic [3:0] WIN_C = 4'(WIN);
  localparam logic [3:0] ON_C  = 4'(ON_TH);
  localparam logic [3:0] OFF_C = 4'(OFF_TH);

  state_t         state_r;
  logic [WIN-1:0] window_r;
  logic [3:0]     fill_r;

  logic           accept_s;
  logic [3:0]     vote_nx_s;
  logic [3:0]     fill_nx_s;
  state_t         state_nx_s;

  // Next state for an accepted sample, given the post-update count and fill.
  function automatic state_t next_state(input state_t cur, input logic [3:0] vote,
                                        input logic full);
    state_t ns;
    ns = cur;
    case (cur)
      FILL: begin
        if (full) ns = (vote >= ON_C) ? READY : NOT_READY;
        else      ns = FILL;
      end
      NOT_READY: begin
        if (vote >= ON_C) ns = READY;
        else              ns = NOT_READY;
      end
      READY: begin
        if (vote <= OFF_C) ns = NOT_READY;
        else               ns = READY;
      end
      default: ns = FILL;
    endcase
    return ns;
  endfunction

  assign accept_s   = ena & cls_valid & ~clr;
  assign vote_nx_s  = vote_cnt + {3'b000, cls_in} - {3'b000, window_r[WIN-1]};
  assign fill_nx_s  = (fill_r == WIN_C) ? fill_r : fill_r + 4'd1;
  assign state_nx_s = next_state(state_r, vote_nx_s, fill_nx_s == WIN_C);

  // Window, counters, FSM and registered outputs; clr acts as a synchronous soft reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      window_r     <= '0;
      fill_r       <= 4'd0;
      vote_cnt     <= 4'd0;
      harvest      <= 1'b0;
      harvest_rise <= 1'b0;
      stable       <= 1'b0;
      event_cnt    <= 8'd0;
    end else if (clr) begin
      state_r      <= FILL;
      window_r     <= '0;
      fill_r       <= 4'd0;
      vote_cnt     <= 4'd0;
      harvest      <= 1'b0;
      harvest_rise <= 1'b0;
      stable       <= 1'b0;
      event_cnt    <= 8'd0;
    end else if (accept_s) begin
      state_r      <= state_nx_s;
      window_r     <= {window_r[WIN-2:0], cls_in};
      fill_r       <= fill_nx_s;
      vote_cnt     <= vote_nx_s;
      stable       <= (fill_nx_s == WIN_C);
      harvest      <= (state_nx_s == READY);
      harvest_rise <= (state_nx_s == READY) && (state_r != READY);
      if ((state_nx_s == READY) && (state_r != READY) && (event_cnt != 8'hFF)) begin
        event_cnt <= event_cnt + 8'd1;
      end else begin
        event_cnt <= event_cnt;
      end
    end else begin
      harvest_rise <= 1'b0;
    end
  end

endmodule

// File: tb/tb_harvest_vote_filter.sv
// Scoreboard bench for harvest_vote_filter: a behavioural model queues expected
// outputs per driven cycle; they are popped and compared one edge later.
module tb_harvest_vote_filter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cls_valid;
  logic       cls_in;
  logic       clr;
  logic       harvest;
  logic       harvest_rise;
  logic       stable;
  logic [3:0] vote_cnt;
  logic [7:0] event_cnt;

  harvest_vote_filter #(.WIN(8), .ON_TH(6), .OFF_TH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cls_valid    (cls_valid),
    .cls_in       (cls_in),
    .clr          (clr),
    .harvest      (harvest),
    .harvest_rise (harvest_rise),
    .stable       (stable),
    .vote_cnt     (vote_cnt),
    .event_cnt    (event_cnt)
  );

  typedef struct {
    logic       harv;
    logic       rise;
    logic       stab;
    logic [3:0] vote;
    logic [7:0] ev;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state: 0 = FILL, 1 = NOT_READY, 2 = READY
  logic [7:0] m_win;
  int         m_fill;
  int         m_state;
  logic       m_rise;
  int         m_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_win = 8'd0; m_fill = 0; m_state = 0; m_rise = 1'b0; m_ev = 0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic d, input logic c);
    int prev;
    int cnt;
    if (c) begin
      model_reset();
    end else if (e && v) begin
      m_win = {m_win[6:0], d};
      if (m_fill < 8) m_fill++;
      cnt  = $countones(m_win);
      prev = m_state;
      if (m_state == 0) begin
        if (m_fill == 8) m_state = (cnt >= 6) ? 2 : 1;
      end else if (m_state == 1) begin
        if (cnt >= 6) m_state = 2;
      end else begin
        if (cnt <= 2) m_state = 1;
      end
      m_rise = (m_state == 2) && (prev != 2);
      if (m_rise && m_ev < 255) m_ev++;
    end else begin
      m_rise = 1'b0;
    end
  endtask

  // drive one cycle of stimulus, queue the model's prediction, compare after the edge
  task automatic step(input logic e, input logic v, input logic d, input logic c);
    exp_t x;
    ena = e; cls_valid = v; cls_in = d; clr = c;
    model_step(e, v, d, c);
    x.harv = (m_state == 2);
    x.rise = m_rise;
    x.stab = (m_fill == 8);
    x.vote = 4'($countones(m_win));
    x.ev   = 8'(m_ev);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("harvest", 32'(harvest), 32'(x.harv));
    check("harvest_rise", 32'(harvest_rise), 32'(x.rise));
    check("stable", 32'(stable), 32'(x.stab));
    check("vote_cnt", 32'(vote_cnt), 32'(x.vote));
    check("event_cnt", 32'(event_cnt), 32'(x.ev));
    ena = 1'b0; cls_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic push_n(input logic d, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, d, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; cls_valid = 1'b0; cls_in = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    check("rst_harvest", 32'(harvest), 32'd0);
    check("rst_vote", 32'(vote_cnt), 32'd0);
    check("rst_stable", 32'(stable), 32'd0);
    check("rst_event", 32'(event_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill and rise
    push_n(1'b1, 7);
    check("fill7_vote", 32'(vote_cnt), 32'd7);
    check("fill7_stable", 32'(stable), 32'd0);
    check("fill7_harvest", 32'(harvest), 32'd0);
    push_n(1'b1, 1);
    check("fill8_stable", 32'(stable), 32'd1);
    check("fill8_harvest", 32'(harvest), 32'd1);
    check("fill8_rise", 32'(harvest_rise), 32'd1);
    check("fill8_event", 32'(event_cnt), 32'd1);
    // ena low with a valid strobe: nothing moves, pending rise drops
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("gate_rise", 32'(harvest_rise), 32'd0);
    check("gate_vote", 32'(vote_cnt), 32'd8);

    // fall hysteresis
    push_n(1'b0, 5);
    check("fall5_vote", 32'(vote_cnt), 32'd3);
    check("fall5_harvest", 32'(harvest), 32'd1);
    push_n(1'b0, 1);
    check("fall6_vote", 32'(vote_cnt), 32'd2);
    check("fall6_harvest", 32'(harvest), 32'd0);

    // re-rise
    push_n(1'b1, 5);
    check("rerise5_vote", 32'(vote_cnt), 32'd5);
    check("rerise5_harvest", 32'(harvest), 32'd0);
    push_n(1'b1, 1);
    check("rerise6_harvest", 32'(harvest), 32'd1);
    check("rerise6_event", 32'(event_cnt), 32'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // clr beats cls_valid, with and without ena
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_vote", 32'(vote_cnt), 32'd0);
    check("clr_harvest", 32'(harvest), 32'd0);
    check("clr_event", 32'(event_cnt), 32'd0);
    push_n(1'b1, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_noena_vote", 32'(vote_cnt), 32'd0);

    // saturation: 300 fall/rise cycles on top of the first rise
    push_n(1'b1, 8);
    for (int k = 0; k < 300; k++) begin
      push_n(1'b0, 6);
      push_n(1'b1, 6);
    end
    check("sat_event", 32'(event_cnt), 32'd255);
    push_n(1'b0, 6);
    push_n(1'b1, 6);
    check("sat_hold_event", 32'(event_cnt), 32'd255);
    check("sat_harvest", 32'(harvest), 32'd1);

    // asynchronous reset between edges while harvest is high
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_harvest", 32'(harvest), 32'd0);
    check("arst_stable", 32'(stable), 32'd0);
    check("arst_vote", 32'(vote_cnt), 32'd0);
    check("arst_event", 32'(event_cnt), 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_n(1'b1, 7);
    check("arst7_harvest", 32'(harvest), 32'd0);
    check("arst7_vote", 32'(vote_cnt), 32'd7);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
